// File: rtl/rp_acq_seq.sv
// Acquisition sequencer for one ADC buffer channel: reset/arm pulses, pre-trigger gating,
// shot counting and holdoff re-arm. Optional auto-trigger timeout under RP_ACQ_SEQ_AUTOTRIG_EN.
module rp_acq_seq #(
    parameter int SHOT_W = 16,
    parameter int HOLD_W = 32
) (
    input  logic              adc_clk_i,
    input  logic              adc_rst_i,
    input  logic              cfg_start_i,
    input  logic              cfg_stop_i,
    input  logic [SHOT_W-1:0] cfg_shots_i,
    input  logic [HOLD_W-1:0] cfg_holdoff_i,
    input  logic [31:0]       cfg_pretrig_i,
    input  logic              trig_i,
    input  logic [31:0]       sm_we_cnt_i,
    input  logic              sm_we_i,
    input  logic              sm_dly_do_i,
    output logic              rst_do_o,
    output logic              arm_do_o,
    output logic              trig_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [SHOT_W-1:0] shot_cnt_o,
    output logic [2:0]        state_o
`ifdef RP_ACQ_SEQ_AUTOTRIG_EN
    ,
    input  logic [31:0]       cfg_timeout_i,
    output logic              autotrig_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_ARM  = 3'd2,
        S_PRE  = 3'd3,
        S_WAIT = 3'd4,
        S_POST = 3'd5,
        S_HOLD = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SHOT_W-1:0] r_shot_cnt;
    logic [SHOT_W-1:0] w_cnt_inc;
    logic [HOLD_W-1:0] r_hold;
    logic              r_done;
    logic              r_stop_rst;
    logic              w_post_exit;
    logic              w_last;
    logic              w_stop;
    logic              w_auto;

    assign w_stop    = cfg_stop_i && (r_state != S_IDLE);
    assign w_cnt_inc = (r_shot_cnt == {SHOT_W{1'b1}}) ? r_shot_cnt
                                                      : r_shot_cnt + {{(SHOT_W-1){1'b0}}, 1'b1};
    assign w_last    = (cfg_shots_i != {SHOT_W{1'b0}}) && (w_cnt_inc == cfg_shots_i);

`ifdef RP_ACQ_SEQ_AUTOTRIG_EN
    logic [31:0] r_tmo;
    logic        r_autotrig;

    // A real trigger on the expiry cycle takes precedence over the auto-trigger
    assign w_auto     = (r_state == S_WAIT) && !trig_i && (cfg_timeout_i != 32'd0) && (r_tmo == 32'd0);
    assign autotrig_o = r_autotrig;

    // Timeout counter reloaded on WAIT entry; auto-trigger flag cleared on re-arm
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_tmo      <= 32'd0;
            r_autotrig <= 1'b0;
        end else begin
            if ((w_next == S_WAIT) && (r_state != S_WAIT)) begin
                r_tmo <= cfg_timeout_i;
            end else if ((r_state == S_WAIT) && (r_tmo != 32'd0)) begin
                r_tmo <= r_tmo - 32'd1;
            end
            if (w_auto && (w_next == S_POST)) begin
                r_autotrig <= 1'b1;
            end else if (w_next == S_RST) begin
                r_autotrig <= 1'b0;
            end
        end
    end
`else
    assign w_auto = 1'b0;
`endif

    // State register
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; stop overrides everything outside IDLE
    always_comb begin
        w_next      = r_state;
        w_post_exit = 1'b0;
        if (w_stop) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start_i && !cfg_stop_i) w_next = S_RST;
                    else                            w_next = S_IDLE;
                end
                S_RST:  w_next = S_ARM;
                S_ARM:  w_next = S_PRE;
                S_PRE: begin
                    if (sm_we_cnt_i >= cfg_pretrig_i) w_next = S_WAIT;
                    else                              w_next = S_PRE;
                end
                S_WAIT: begin
                    if (trig_i || w_auto) w_next = S_POST;
                    else                  w_next = S_WAIT;
                end
                S_POST: begin
                    if (!sm_we_i && !sm_dly_do_i) begin
                        w_post_exit = 1'b1;
                        w_next      = w_last ? S_IDLE : S_HOLD;
                    end else begin
                        w_next = S_POST;
                    end
                end
                S_HOLD: begin
                    if (r_hold == {HOLD_W{1'b0}}) w_next = S_RST;
                    else                          w_next = S_HOLD;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Shot counter, holdoff counter, done pulse and post-stop buffer reset pulse
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_shot_cnt <= {SHOT_W{1'b0}};
            r_hold     <= {HOLD_W{1'b0}};
            r_done     <= 1'b0;
            r_stop_rst <= 1'b0;
        end else begin
            r_done     <= w_post_exit && w_last;
            r_stop_rst <= w_stop;
            if ((r_state == S_IDLE) && (w_next == S_RST)) begin
                r_shot_cnt <= {SHOT_W{1'b0}};
            end else if (w_post_exit) begin
                r_shot_cnt <= w_cnt_inc;
            end
            if (w_post_exit && !w_last) begin
                r_hold <= cfg_holdoff_i;
            end else if ((r_state == S_HOLD) && (r_hold != {HOLD_W{1'b0}})) begin
                r_hold <= r_hold - {{(HOLD_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rst_do_o   = (r_state == S_RST) || r_stop_rst;
    assign arm_do_o   = (r_state == S_ARM);
    assign trig_o     = (trig_i && (r_state == S_WAIT)) || w_auto;
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = r_done;
    assign shot_cnt_o = r_shot_cnt;
    assign state_o    = r_state;

endmodule

// File: tb/tb_rp_acq_seq.sv
// Self-checking bench for rp_acq_seq: directed scenarios plus randomized runs, expectations
// derived from the sequencing rules as a per-cycle timeline.
module tb_rp_acq_seq;
    localparam int SW   = 3;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          adc_rst_i = 1'b1;
    logic          cfg_start_i = 1'b0;
    logic          cfg_stop_i = 1'b0;
    logic [SW-1:0] cfg_shots_i = '0;
    logic [31:0]   cfg_holdoff_i = '0;
    logic [31:0]   cfg_pretrig_i = '0;
    logic          trig_i = 1'b0;
    logic [31:0]   sm_we_cnt_i = '0;
    logic          sm_we_i = 1'b0;
    logic          sm_dly_do_i = 1'b0;
    logic          rst_do_o, arm_do_o, trig_o, busy_o, done_o;
    logic [SW-1:0] shot_cnt_o;
    logic [2:0]    state_o;
`ifdef RP_ACQ_SEQ_AUTOTRIG_EN
    logic [31:0]   cfg_timeout_i = '0;
    logic          autotrig_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    rp_acq_seq #(.SHOT_W(SW), .HOLD_W(32)) dut (
        .adc_clk_i(clk), .adc_rst_i(adc_rst_i), .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
        .cfg_shots_i(cfg_shots_i), .cfg_holdoff_i(cfg_holdoff_i), .cfg_pretrig_i(cfg_pretrig_i),
        .trig_i(trig_i), .sm_we_cnt_i(sm_we_cnt_i), .sm_we_i(sm_we_i), .sm_dly_do_i(sm_dly_do_i),
        .rst_do_o(rst_do_o), .arm_do_o(arm_do_o), .trig_o(trig_o), .busy_o(busy_o),
        .done_o(done_o), .shot_cnt_o(shot_cnt_o), .state_o(state_o)
`ifdef RP_ACQ_SEQ_AUTOTRIG_EN
        , .cfg_timeout_i(cfg_timeout_i), .autotrig_o(autotrig_o)
`endif
    );

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    // Check one cycle: {state, rst_do, arm_do, trig, done, busy, count}, then advance to next negedge
    task automatic cyc(input string tag, input int st, input bit rd, input bit ad,
                       input bit tg, input bit dn, input int cnt);
        logic [SW+7:0] obs;
        logic [SW+7:0] exp;
        #1;
        obs = {state_o, rst_do_o, arm_do_o, trig_o, done_o, busy_o, shot_cnt_o};
        exp = {3'(st), rd, ad, tg, dn, (st != 0), SW'(cnt)};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (st,rst,arm,trig,done,busy,cnt)", tag, obs, exp);
        end
        @(negedge clk);
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int shots, input int hold, input int pre);
        cfg_shots_i = SW'(shots); cfg_holdoff_i = hold; cfg_pretrig_i = pre;
        cfg_start_i = 1'b1;
        cyc("start", 0, 0, 0, 0, 0, exp_cnt);
        cfg_start_i = 1'b0;
        exp_cnt = 0;
    endtask

    // RST, ARM, then PRE with the sample count rising by one per cycle; a trigger mid-PRE is dropped
    task automatic arm_to_wait(input int cb, input int pre);
        trig_i = 1'b0; sm_we_i = 1'b0; sm_dly_do_i = 1'b0; sm_we_cnt_i = 0;
        cyc("rst", 1, 1, 0, 0, 0, cb);
        cyc("arm", 2, 0, 1, 0, 0, cb);
        for (int j = 0; j <= pre; j++) begin
            sm_we_cnt_i = j;
            trig_i = (j == pre / 2) ? 1'b1 : 1'($urandom_range(0, 1));
            cyc("pre", 3, 0, 0, 0, 0, cb);
        end
        trig_i = 1'b0;
    endtask

    // WAIT for tdel cycles, trigger, POST busy for plen cycles, then done or hold_cycles of HOLD
    task automatic finish_shot(input int cb, input int ca, input bit last, input int hold_cycles,
                               input int tdel, input int plen, input int pre);
        for (int d = 0; d < tdel; d++) begin
            sm_we_cnt_i = pre + 1 + d; trig_i = 1'b0;
            cyc("wait", 4, 0, 0, 0, 0, cb);
        end
        sm_we_cnt_i = pre + 1 + tdel; trig_i = 1'b1;
        cyc("trig", 4, 0, 0, 1, 0, cb);
        for (int p = 0; p < plen; p++) begin
            trig_i = 1'($urandom_range(0, 1));
            {sm_we_i, sm_dly_do_i} = 2'($urandom_range(1, 3));
            cyc("post", 5, 0, 0, 0, 0, cb);
        end
        trig_i = 1'($urandom_range(0, 1)); sm_we_i = 1'b0; sm_dly_do_i = 1'b0;
        cyc("post_exit", 5, 0, 0, 0, 0, cb);
        trig_i = 1'b0;
        if (last) begin
            cyc("done", 0, 0, 0, 0, 1, ca);
            cyc("idle_after_done", 0, 0, 0, 0, 0, ca);
        end else begin
            for (int h = 0; h < hold_cycles; h++) cyc("hold", 6, 0, 0, 0, 0, ca);
        end
        exp_cnt = ca;
    endtask

    task automatic run_seq(input int shots, input int hold, input int pre, input bit rnd,
                           input int tdel, input int plen);
        start_run(shots, hold, pre);
        for (int k = 1; k <= shots; k++) begin
            arm_to_wait(sat(k - 1), pre);
            finish_shot(sat(k - 1), sat(k), k == shots, hold + 1,
                        rnd ? int'($urandom_range(0, 8)) : tdel,
                        rnd ? int'($urandom_range(0, 10)) : plen, pre);
        end
    endtask

    // Continuous run of n shots, then stop while waiting for a trigger
    task automatic cont_then_stop(input int n, input int hold);
        start_run(0, hold, 2);
        for (int k = 1; k <= n; k++) begin
            arm_to_wait(sat(k - 1), 2);
            finish_shot(sat(k - 1), sat(k), 1'b0, hold + 1, 1, 2, 2);
        end
        arm_to_wait(sat(n), 2);
        cfg_stop_i = 1'b1;
        cyc("stop_in_wait", 4, 0, 0, 0, 0, sat(n));
        cfg_stop_i = 1'b0;
        cyc("stop_rst_pulse", 0, 1, 0, 0, 0, sat(n));
        cyc("stop_idle", 0, 0, 0, 0, 0, sat(n));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        cyc("reset_held", 0, 0, 0, 0, 0, 0);
        adc_rst_i = 1'b0;
        cyc("reset_release", 0, 0, 0, 0, 0, 0);

        // Single shot, zero pretrigger and holdoff, POST held 10 cycles
        run_seq(1, 0, 0, 1'b0, 2, 10);
        // Pretrigger 100: trigger at sample 50 dropped, trigger at sample 120 accepted
        run_seq(1, 0, 100, 1'b0, 19, 3);
        // Three shots with holdoff 5
        run_seq(3, 5, 4, 1'b0, 3, 4);
        // Continuous: five shots then stop; then past saturation
        cont_then_stop(5, 1);
        cont_then_stop(9, 0);

        // Start and stop together in IDLE
        cfg_start_i = 1'b1; cfg_stop_i = 1'b1;
        cyc("start_stop_idle", 0, 0, 0, 0, 0, exp_cnt);
        cfg_start_i = 1'b0; cfg_stop_i = 1'b0;
        cyc("start_stop_after", 0, 0, 0, 0, 0, exp_cnt);
        cfg_stop_i = 1'b1;
        cyc("stop_in_idle", 0, 0, 0, 0, 0, exp_cnt);
        cfg_stop_i = 1'b0;
        cyc("stop_in_idle_after", 0, 0, 0, 0, 0, exp_cnt);

        // Reset asserted during HOLD
        start_run(2, 10, 0);
        arm_to_wait(0, 0);
        finish_shot(0, 1, 1'b0, 3, 0, 1, 0);
        adc_rst_i = 1'b1;
        cyc("rst_in_hold", 6, 0, 0, 0, 0, 1);
        adc_rst_i = 1'b0;
        cyc("after_sync_rst", 0, 0, 0, 0, 0, 0);
        exp_cnt = 0;

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            run_seq(int'($urandom_range(1, 3)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 15)), 1'b1, 0, 0);
        end

`ifdef RP_ACQ_SEQ_AUTOTRIG_EN
        // Auto-trigger after 20 WAIT cycles with no trigger
        cfg_timeout_i = 32'd20;
        start_run(1, 0, 0);
        arm_to_wait(0, 0);
        for (int d = 0; d < 20; d++) begin
            chk_bit("autotrig_wait", autotrig_o, 1'b0);
            cyc("auto_wait", 4, 0, 0, 0, 0, 0);
        end
        cyc("auto_fire", 4, 0, 0, 1, 0, 0);
        chk_bit("autotrig_set", autotrig_o, 1'b1);
        cyc("auto_post_exit", 5, 0, 0, 0, 0, 0);
        cyc("auto_done", 0, 0, 0, 0, 1, 1);
        chk_bit("autotrig_held", autotrig_o, 1'b1);
        exp_cnt = 1;
        cfg_timeout_i = 32'd0;
        start_run(1, 0, 0);
        chk_bit("autotrig_cleared_rst", autotrig_o, 1'b0);
        arm_to_wait(0, 0);
        finish_shot(0, 1, 1'b1, 1, 30, 1, 0);
        chk_bit("autotrig_real", autotrig_o, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
